// File: rtl/rb_addr_responder_if.sv
// Bundle between control_module, the row-buffer address responder and the memories.
// The master drives the step strobes; the slave returns addresses and occupancy status.
interface rb_addr_responder_if #(
    parameter int E_AW = 16,
    parameter int B_AW = 10
);
    logic            start;
    logic            en_e_mem_addr;
    logic            en_w_bram_addr;
    logic            en_r_bram_addr;
    logic [E_AW-1:0] e_mem_addr;
    logic [B_AW-1:0] w_bram_addr;
    logic [B_AW-1:0] r_bram_addr;
    logic [B_AW:0]   count;
    logic            full;
    logic            empty;
    logic            e_done;
    logic            overrun;
    logic            underrun;
    logic            done;

    modport master (
        output start, en_e_mem_addr, en_w_bram_addr, en_r_bram_addr,
        input  e_mem_addr, w_bram_addr, r_bram_addr, count,
        input  full, empty, e_done, overrun, underrun, done
    );

    modport slave (
        input  start, en_e_mem_addr, en_w_bram_addr, en_r_bram_addr,
        output e_mem_addr, w_bram_addr, r_bram_addr, count,
        output full, empty, e_done, overrun, underrun, done
    );
endinterface

// File: rtl/rb_addr_responder.sv
// Row-buffer address responder: external read address, circular BRAM write/read
// addresses and occupancy tracking with sticky overrun/underrun flags.
module rb_addr_responder #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int K     = 3,
    parameter int E_AW  = 16,
    parameter int B_AW  = 10
) (
    input  logic                clk,
    input  logic                rst,
    rb_addr_responder_if.slave  bus
);
    localparam int              DEPTH   = K * IMG_W;
    localparam logic [B_AW:0]   DEPTH_C = (B_AW+1)'(DEPTH);
    localparam logic [B_AW-1:0] LAST_B  = B_AW'(DEPTH - 1);
    localparam logic [E_AW-1:0] LAST_E  = E_AW'(IMG_W * IMG_H - 1);

    function automatic logic [B_AW-1:0] wrap_inc(input logic [B_AW-1:0] a);
        return (a == LAST_B) ? '0 : a + 1'b1;
    endfunction

    logic [E_AW-1:0] e_addr;
    logic [B_AW-1:0] w_addr;
    logic [B_AW-1:0] r_addr;
    logic [B_AW:0]   cnt;
    logic            e_done_q;
    logic            overrun_q;
    logic            underrun_q;

    logic full_c;
    logic empty_c;
    logic rd_ok;
    logic wr_ok;

    assign full_c  = (cnt == DEPTH_C);
    assign empty_c = (cnt == '0);
    // A read frees a slot in the same cycle, so a write while full still fits.
    assign rd_ok   = bus.en_r_bram_addr & ~empty_c;
    assign wr_ok   = bus.en_w_bram_addr & (~full_c | rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_addr     <= '0;
            w_addr     <= '0;
            r_addr     <= '0;
            cnt        <= '0;
            e_done_q   <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else if (bus.start) begin
            e_addr     <= '0;
            w_addr     <= '0;
            r_addr     <= '0;
            cnt        <= '0;
            e_done_q   <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (bus.en_e_mem_addr && !e_done_q) begin
                if (e_addr == LAST_E) begin
                    e_done_q <= 1'b1;
                end else begin
                    e_addr <= e_addr + 1'b1;
                end
            end

            if (wr_ok) begin
                w_addr <= wrap_inc(w_addr);
            end else if (bus.en_w_bram_addr) begin
                overrun_q <= 1'b1;
            end

            if (rd_ok) begin
                r_addr <= wrap_inc(r_addr);
            end else if (bus.en_r_bram_addr) begin
                underrun_q <= 1'b1;
            end

            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.e_mem_addr  = e_addr;
    assign bus.w_bram_addr = w_addr;
    assign bus.r_bram_addr = r_addr;
    assign bus.count       = cnt;
    assign bus.full        = full_c;
    assign bus.empty       = empty_c;
    assign bus.e_done      = e_done_q;
    assign bus.overrun     = overrun_q;
    assign bus.underrun    = underrun_q;
    assign bus.done        = e_done_q & empty_c;
endmodule

// File: tb/tb_rb_addr_responder.sv
// Directed bench for rb_addr_responder: a vector table for single-cycle behaviour
// plus hand sequences for fill/wrap, sustained traffic, reset and external end.
module tb_rb_addr_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rb_addr_responder_if #(.E_AW(16), .B_AW(10)) bus ();

    rb_addr_responder #(
        .IMG_W(256), .IMG_H(256), .K(3), .E_AW(16), .B_AW(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic s, e, w, r;
        int   cnt, wa, ra;
        logic fu, em, ov, un;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic e, input logic w, input logic r);
        bus.start          = s;
        bus.en_e_mem_addr  = e;
        bus.en_w_bram_addr = w;
        bus.en_r_bram_addr = r;
        @(posedge clk);
        #1;
        bus.start          = 1'b0;
        bus.en_e_mem_addr  = 1'b0;
        bus.en_w_bram_addr = 1'b0;
        bus.en_r_bram_addr = 1'b0;
    endtask

    task automatic cycn(input int n, input logic e, input logic w, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, e, w, r);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.start          = 1'b0;
        bus.en_e_mem_addr  = 1'b0;
        bus.en_w_bram_addr = 1'b0;
        bus.en_r_bram_addr = 1'b0;

        // start, e, w, r, count, w_addr, r_addr, full, empty, overrun, underrun
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 3, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 4, 3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state while rst is held
        rst = 1'b1;
        #12;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full",  int'(bus.full), 0);
        chk("rst_eaddr", int'(bus.e_mem_addr), 0);
        chk("rst_done",  int'(bus.done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].s, tbl[i].e, tbl[i].w, tbl[i].r);
            chk($sformatf("v%0d_count", i), int'(bus.count), tbl[i].cnt);
            chk($sformatf("v%0d_waddr", i), int'(bus.w_bram_addr), tbl[i].wa);
            chk($sformatf("v%0d_raddr", i), int'(bus.r_bram_addr), tbl[i].ra);
            chk($sformatf("v%0d_full", i),  int'(bus.full), int'(tbl[i].fu));
            chk($sformatf("v%0d_empty", i), int'(bus.empty), int'(tbl[i].em));
            chk($sformatf("v%0d_ovr", i),   int'(bus.overrun), int'(tbl[i].ov));
            chk($sformatf("v%0d_und", i),   int'(bus.underrun), int'(tbl[i].un));
        end

        // Asynchronous reset mid-stream with five entries held
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cycn(5, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_count", int'(bus.count), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_count", int'(bus.count), 0);
        chk("async_waddr", int'(bus.w_bram_addr), 0);
        chk("async_eaddr", int'(bus.e_mem_addr), 0);
        chk("async_empty", int'(bus.empty), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("first_waddr", int'(bus.w_bram_addr), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("second_waddr", int'(bus.w_bram_addr), 1);

        // Fill, overrun, drain
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cycn(768, 1'b0, 1'b1, 1'b0);
        chk("fill_full",  int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 768);
        chk("fill_waddr", int'(bus.w_bram_addr), 0);
        chk("fill_ovr",   int'(bus.overrun), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_flag",  int'(bus.overrun), 1);
        chk("ovr_waddr", int'(bus.w_bram_addr), 0);
        chk("ovr_count", int'(bus.count), 768);
        cycn(768, 1'b0, 1'b0, 1'b1);
        chk("drain_empty", int'(bus.empty), 1);
        chk("drain_raddr", int'(bus.r_bram_addr), 0);
        chk("drain_und",   int'(bus.underrun), 0);

        // Write and read together from full
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cycn(768, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("fullwr_count", int'(bus.count), 768);
        chk("fullwr_waddr", int'(bus.w_bram_addr), 1);
        chk("fullwr_raddr", int'(bus.r_bram_addr), 1);
        chk("fullwr_ovr",   int'(bus.overrun), 0);

        // Sustained simultaneous traffic from count 3
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cycn(3, 1'b0, 1'b1, 1'b0);
        cycn(1000, 1'b0, 1'b1, 1'b1);
        chk("sim_count", int'(bus.count), 3);
        chk("sim_waddr", int'(bus.w_bram_addr), 235);
        chk("sim_raddr", int'(bus.r_bram_addr), 232);

        // External address end with two entries buffered
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cycn(2, 1'b0, 1'b1, 1'b0);
        cycn(65535, 1'b1, 1'b0, 1'b0);
        chk("e_last_addr", int'(bus.e_mem_addr), 65535);
        chk("e_last_done", int'(bus.e_done), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("e_end_addr", int'(bus.e_mem_addr), 65535);
        chk("e_end_done", int'(bus.e_done), 1);
        chk("done_busy",  int'(bus.done), 0);
        cycn(3, 1'b1, 1'b0, 1'b0);
        chk("e_hold_addr", int'(bus.e_mem_addr), 65535);
        cycn(2, 1'b0, 1'b0, 1'b1);
        chk("done_drained", int'(bus.done), 1);

        // Start beats every enable in the same cycle
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("st_eaddr",  int'(bus.e_mem_addr), 0);
        chk("st_edone",  int'(bus.e_done), 0);
        chk("st_count",  int'(bus.count), 0);
        chk("st_waddr",  int'(bus.w_bram_addr), 0);
        chk("st_raddr",  int'(bus.r_bram_addr), 0);
        chk("st_done",   int'(bus.done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
